// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader
// Description : Instruction memory with a byte-stream program loader.
//               Incoming bytes are packed little-endian into 32-bit words
//               and written from word address 0 upward.  The CPU is held in
//               reset (o_cpu_reset_n = 0) until the load has finished.  A
//               registered read port serves the fetch stage at all times.
//
// Ports       :
//   i_clk           clock, rising edge
//   i_reset         synchronous active-low reset
//   i_start         one-cycle pulse, starts a load of i_word_count words
//   i_word_count    words to load (ADDR_W+1 bits, clamped to DEPTH)
//   i_rx_valid      byte-stream valid
//   i_rx_data       byte-stream data
//   o_rx_ready      byte-stream ready
//   o_busy          load in progress
//   o_done          load complete
//   o_error         checksum failure (constant 0 without the checksum option)
//   o_cpu_reset_n   active-low reset for fetch/CPU logic
//   i_address       fetch read address
//   o_instruction   registered read data, one cycle latency
//
// Options     : `define INST_MEM_LOADER_CHECKSUM_EN adds a CHECK state.  After
//               the payload, one extra byte is accepted that must equal the
//               modulo-256 sum of all payload bytes.
//
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,  // must equal 2**ADDR_W
  parameter int DATA_W = 32     // fixed at 4 bytes
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_word_count,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_cpu_reset_n,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] o_instruction
);

  localparam logic [ADDR_W:0] c_depth_cnt = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_one_cnt   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]        r_byte_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words_left;
  logic [23:0]       r_word_buf;    // first three bytes of the word in flight

  logic              w_xfer;
  logic              w_write;
  logic              w_load_start;
  logic              w_error_next;
  logic [ADDR_W:0]   w_count_clamped;

  assign w_xfer          = i_rx_valid && o_rx_ready;
  assign w_count_clamped = (i_word_count > c_depth_cnt) ? c_depth_cnt : i_word_count;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic       r_error;
  logic [7:0] r_sum;
  assign o_error = r_error;
`else
  assign o_error = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load_start = 1'b0;
    w_write      = 1'b0;
    w_error_next = o_error;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_error_next = 1'b0;
          if (i_word_count == '0) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_LOAD;
            w_load_start = 1'b1;
          end
        end
      end

      S_LOAD: begin
        // i_start is deliberately not looked at here
        if (w_xfer && (r_byte_idx == 2'd3)) begin
          w_write = 1'b1;
          if (r_words_left == c_one_cnt) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            w_state_next = S_CHECK;
`else
            w_state_next = S_DONE;
`endif
          end
        end
      end

`ifdef INST_MEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_xfer) begin
          w_state_next = S_DONE;
          w_error_next = (i_rx_data != r_sum);
        end
      end
`endif

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered state-derived outputs.  They are computed from the next state
  // so they line up with r_state without an extra cycle of lag.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_rx_ready    <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_cpu_reset_n <= 1'b0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      r_error       <= 1'b0;
`endif
    end else begin
      o_rx_ready    <= (w_state_next == S_LOAD) || (w_state_next == S_CHECK);
      o_busy        <= (w_state_next == S_LOAD) || (w_state_next == S_CHECK);
      o_done        <= (w_state_next == S_DONE);
      // a failed checksum completes the load but keeps the CPU in reset
      o_cpu_reset_n <= (w_state_next == S_DONE) && !w_error_next;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      r_error       <= w_error_next;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Byte assembly, address and word counter
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_byte_idx   <= 2'd0;
      r_addr       <= '0;
      r_words_left <= '0;
      r_word_buf   <= '0;
    end else if (w_load_start) begin
      r_byte_idx   <= 2'd0;
      r_addr       <= '0;
      r_words_left <= w_count_clamped;
      r_word_buf   <= '0;
    end else if ((r_state == S_LOAD) && w_xfer) begin
      r_byte_idx <= r_byte_idx + 2'd1;
      case (r_byte_idx)
        2'd0:    r_word_buf[7:0]   <= i_rx_data;
        2'd1:    r_word_buf[15:8]  <= i_rx_data;
        2'd2:    r_word_buf[23:16] <= i_rx_data;
        default: begin
          // address wraps to 0 after a full-depth load; the FSM has left
          // LOAD by then so no further write follows
          r_addr       <= r_addr + 1'b1;
          r_words_left <= r_words_left - c_one_cnt;
        end
      endcase
    end
  end

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_sum <= 8'd0;
    end else if (w_load_start) begin
      r_sum <= 8'd0;
    end else if ((r_state == S_LOAD) && w_xfer) begin
      r_sum <= r_sum + i_rx_data;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Memory: write on the fourth byte, registered read.  Contents survive
  // reset.  A same-edge read of the written address returns the old word.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_mem[r_addr] <= {i_rx_data, r_word_buf};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_instruction <= '0;
    end else begin
      o_instruction <= r_mem[i_address];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mem_loader
// Description : Self-checking bench for inst_mem_loader.  A word-level model
//               of memory contents (associative array) is built from the byte
//               stream sent; outputs are compared against protocol rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_start = 1'b0;
  logic [ADDR_W:0]   i_word_count = '0;
  logic              i_rx_valid = 1'b0;
  logic [7:0]        i_rx_data = 8'd0;
  logic              o_rx_ready;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic              o_cpu_reset_n;
  logic [ADDR_W-1:0] i_address = '0;
  logic [31:0]       o_instruction;

  int n_checks = 0;
  int n_fail   = 0;

  bit [31:0]   model_mem [int];
  bit [7:0]    byte_q [$];

  inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_word_count(i_word_count), .i_rx_valid(i_rx_valid),
    .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_cpu_reset_n(o_cpu_reset_n),
    .i_address(i_address), .o_instruction(o_instruction)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic make_bytes(input int nbytes);
    byte_q.delete();
    for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom));
  endtask

  // Runs a complete load of byte_q, updates the model and checks handshake.
  task automatic do_load(input int count, input int max_gap, input int gap5_at,
                         input bit poke_start, input bit bad_sum);
    int     eff;
    int     g;
    bit     err;
    bit [7:0] sum;
    eff = (count > DEPTH) ? DEPTH : count;
    err = 1'b0;
    sum = 8'd0;
    i_start = 1'b1;
    i_word_count = (ADDR_W+1)'(count);
    tick();
    i_start = 1'b0;
    if (count == 0) begin
      n_checks++;
      if (o_done !== 1'b1 || o_cpu_reset_n !== 1'b1 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_count: done=%b cpu_rst_n=%b busy=%b, required 1 1 0",
                 o_done, o_cpu_reset_n, o_busy);
      end
      return;
    end
    n_checks++;
    if (o_busy !== 1'b1 || o_rx_ready !== 1'b1 || o_cpu_reset_n !== 1'b0 ||
        o_done !== 1'b0 || o_error !== 1'b0) begin
      n_fail++;
      $display("FAIL load_entry: busy=%b rdy=%b cpu_rst_n=%b done=%b err=%b, required 1 1 0 0 0",
               o_busy, o_rx_ready, o_cpu_reset_n, o_done, o_error);
    end
    for (int i = 0; i < eff * 4; i++) begin
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      if (i == gap5_at) g = 5;
      for (int k = 0; k < g; k++) begin
        if (poke_start && k == 0) begin
          i_start = 1'b1;
          i_word_count = '0;
        end
        tick();
        i_start = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_busy: busy=%b done=%b at byte %0d, required 1 0", o_busy, o_done, i);
        end
      end
      i_rx_valid = 1'b1;
      i_rx_data  = byte_q[i];
      sum += byte_q[i];
      tick();
      i_rx_valid = 1'b0;
    end
    for (int w = 0; w < eff; w++)
      model_mem[w] = {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    n_checks++;
    if (o_rx_ready !== 1'b1 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL check_wait: rdy=%b done=%b, required 1 0", o_rx_ready, o_done);
    end
    err = bad_sum;
    i_rx_valid = 1'b1;
    i_rx_data  = bad_sum ? sum + 8'd1 : sum;
    tick();
    i_rx_valid = 1'b0;
`endif
    n_checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_rx_ready !== 1'b0 ||
        o_cpu_reset_n !== !err || o_error !== err) begin
      n_fail++;
      $display("FAIL load_done: done=%b busy=%b rdy=%b cpu_rst_n=%b err=%b, required 1 0 0 %b %b",
               o_done, o_busy, o_rx_ready, o_cpu_reset_n, o_error, !err, err);
    end
    // an extra offered byte must not be accepted once done
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hFF;
    tick();
    i_rx_valid = 1'b0;
    n_checks++;
    if (o_rx_ready !== 1'b0 || o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_idle: rdy=%b done=%b, required 0 1", o_rx_ready, o_done);
    end
  endtask

  task automatic verify_mem();
    foreach (model_mem[a]) begin
      i_address = ADDR_W'(a);
      tick();
      n_checks++;
      if (o_instruction !== model_mem[a]) begin
        n_fail++;
        $display("FAIL mem_read[%0d]: got %h expected %h", a, o_instruction, model_mem[a]);
      end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rx_ready !== 1'b0 ||
        o_error !== 1'b0 || o_cpu_reset_n !== 1'b0 || o_instruction !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b rdy=%b err=%b cpu_rst_n=%b instr=%h, required all 0",
               o_busy, o_done, o_rx_ready, o_error, o_cpu_reset_n, o_instruction);
    end
    i_reset = 1'b1;
    tick();
    n_checks++;
    if (o_cpu_reset_n !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_state: cpu_rst_n=%b busy=%b, required 0 0", o_cpu_reset_n, o_busy);
    end
  endtask

  task automatic test_basic();
    byte_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(2, 0, -1, 1'b0, 1'b0);
    i_address = 12'd1;
    tick();
    n_checks++;
    if (o_instruction !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_word1: got %h expected deadbeef", o_instruction);
    end
    verify_mem();
  endtask

  task automatic test_gaps();
    // same bytes, five idle cycles between bytes 2 and 3, stray i_start poke
    byte_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(2, 0, 2, 1'b1, 1'b0);
    verify_mem();
  endtask

  task automatic test_count_zero();
    do_load(0, 0, -1, 1'b0, 1'b0);
    verify_mem();
  endtask

  task automatic test_reset_midload();
    make_bytes(12);
    i_start = 1'b1;
    i_word_count = 13'd3;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_rx_valid = 1'b1;
      i_rx_data  = byte_q[i];
      tick();
    end
    i_rx_valid = 1'b0;
    model_mem[0] = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
    i_reset = 1'b0;
    tick();
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_cpu_reset_n !== 1'b0 || o_rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset: busy=%b done=%b cpu_rst_n=%b rdy=%b, required 0 0 0 0",
               o_busy, o_done, o_cpu_reset_n, o_rx_ready);
    end
    i_reset = 1'b1;
    tick();
    verify_mem();
    byte_q = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    do_load(1, 0, -1, 1'b0, 1'b0);
    i_address = '0;
    tick();
    n_checks++;
    if (o_instruction !== 32'hAABBCCDD) begin
      n_fail++;
      $display("FAIL reload_word0: got %h expected aabbccdd", o_instruction);
    end
  endtask

  task automatic test_read_during_write();
    bit [31:0] old_w;
    bit [31:0] new_w;
    old_w = model_mem[0];
    make_bytes(4);
    new_w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
    i_address = '0;
    i_start = 1'b1;
    i_word_count = 13'd1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_rx_valid = 1'b1;
      i_rx_data  = byte_q[i];
      tick();
    end
    i_rx_valid = 1'b0;
    n_checks++;
    if (o_instruction !== old_w) begin
      n_fail++;
      $display("FAIL rdw_old: got %h expected %h", o_instruction, old_w);
    end
    tick();
    n_checks++;
    if (o_instruction !== new_w) begin
      n_fail++;
      $display("FAIL rdw_new: got %h expected %h", o_instruction, new_w);
    end
    model_mem[0] = new_w;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    i_rx_valid = 1'b1;
    i_rx_data  = byte_q[0] + byte_q[1] + byte_q[2] + byte_q[3];
    tick();
    i_rx_valid = 1'b0;
`endif
    tick();
    n_checks++;
    if (o_done !== 1'b1 || o_cpu_reset_n !== 1'b1) begin
      n_fail++;
      $display("FAIL rdw_done: done=%b cpu_rst_n=%b, required 1 1", o_done, o_cpu_reset_n);
    end
  endtask

  task automatic test_random();
    int cnt;
    for (int t = 0; t < 4; t++) begin
      cnt = $urandom_range(1, 9);
      make_bytes(cnt * 4);
      do_load(cnt, 3, -1, 1'b0, 1'b0);
    end
    verify_mem();
  endtask

  task automatic test_full_depth();
    // count above DEPTH is clamped; address wraps but word 0 is not rewritten
    make_bytes(DEPTH * 4);
    do_load(DEPTH + 1, 0, -1, 1'b0, 1'b0);
    verify_mem();
  endtask

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load(1, 0, -1, 1'b0, 1'b0);
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load(1, 0, -1, 1'b0, 1'b1);
    make_bytes(8);
    do_load(2, 2, -1, 1'b0, 1'b0);
    verify_mem();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_count_zero();
    test_reset_midload();
    test_read_during_write();
    test_random();
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_full_depth();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Instruction memory with two sides: a byte-stream program-load write side and a registered read port for the fetch stage.
- The loader assembles incoming bytes into 32-bit words and writes them from address 0 upward.
- It holds the CPU in reset until the load completes, then releases it so fetch reads the loaded program starting at PC 0.

Parameters:
- ADDR_W, 12, word-address width; matches the 12-bit fetch PC.
- DEPTH, 4096, number of 32-bit words (must equal 2**ADDR_W).
- DATA_W, 32, instruction width (fixed at 4 bytes).

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle pulse; begins a load of i_word_count words.
- i_word_count  in  ADDR_W+1  number of words to load; sampled on i_start.
- i_rx_valid  in  1  byte-stream valid.
- i_rx_data  in  8  byte-stream data.
- o_rx_ready  out  1  byte-stream ready.
- o_busy  out  1  load in progress.
- o_done  out  1  load complete, CPU released.
- o_error  out  1  checksum failure (only with CHECKSUM_EN; otherwise tied 0).
- o_cpu_reset_n  out  1  active-low reset for the fetch/CPU logic.
- i_address  in  ADDR_W  read address from fetch.
- o_instruction  out  DATA_W  registered read data.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_reset; it is sampled only at the rising edge of i_clk.
- Reset values:
  - State IDLE.
  - o_rx_ready=0, o_busy=0, o_done=0, o_error=0, o_cpu_reset_n=0, o_instruction=0.
  - Byte index, word address and word counter all 0.
  - Memory contents are NOT cleared.
- States: IDLE, LOAD, CHECK (CHECKSUM_EN only), DONE. State-derived outputs are registered.
- IDLE: o_cpu_reset_n=0.
  - i_start with i_word_count=0 -> DONE.
  - i_start with nonzero count -> LOAD. Count is clamped to DEPTH if larger; address=0, byte index=0.
- LOAD: o_busy=1, o_rx_ready=1, o_cpu_reset_n=0.
  - A byte transfers on any edge where i_rx_valid && o_rx_ready.
  - Bytes are little-endian: the first byte goes to bits [7:0], the fourth to bits [31:24].
  - On the 4th byte, the assembled word is written to mem[address] at that same edge; address increments and the byte index wraps to 0.
  - When the last word is written: -> DONE, or -> CHECK with CHECKSUM_EN.
  - i_rx_valid gaps of any length are allowed.
  - i_start is ignored while in LOAD.
- DONE: o_done=1, o_busy=0, o_rx_ready=0, o_cpu_reset_n=1 (CPU starts fetching at PC 0 on the next cycle).
  - i_start restarts the load: o_cpu_reset_n=0 from the next cycle, and the same entry rules as IDLE apply.
- Read port:
  - Every cycle, o_instruction <= mem[i_address]; 1-cycle latency, independent of loader state.
  - Read and write to the same address on the same edge returns the OLD data.
- Loading all DEPTH words: the address wraps to 0 internally after the last write, but no further write occurs.
- i_reset low mid-load:
  - Returns to IDLE at that edge; partial byte assembly is discarded.
  - Words already written remain in memory.
  - o_cpu_reset_n stays 0.

Optional Feature:
- Macro: INST_MEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, the block enters CHECK with o_rx_ready=1 and accepts one byte.
  - That byte must equal the 8-bit modulo-256 sum of all payload bytes.
  - Match -> DONE, o_error=0.
  - Mismatch -> DONE with o_error=1 and o_done=1, but o_cpu_reset_n held 0.
  - o_error clears on the next i_start or reset.
  - A count of 0 skips CHECK; the checksum is not required.
- Not defined:
  - No CHECK state; o_error is constant 0.
  - The load completes after the last payload byte.

Test Plan:
- Reset, then i_start with count=2 and bytes 78 56 34 12 EF BE AD DE sent back-to-back -> mem[0]=0x12345678, mem[1]=0xDEADBEEF; o_done=1 and o_cpu_reset_n=1 one edge after the last byte; i_address=1 -> o_instruction=0xDEADBEEF on the next cycle.
- Same load with i_rx_valid deasserted for 5 cycles between bytes 2 and 3 -> identical memory result; o_busy stays 1 throughout; no extra bytes are consumed.
- i_start with count=0 -> DONE on the next edge; o_cpu_reset_n=1; memory unchanged.
- Start a 3-word load; assert i_reset low after 6 bytes -> IDLE, o_cpu_reset_n=0, mem[0] holds word 0; reload 1 word 0xAABBCCDD -> mem[0]=0xAABBCCDD.
- Read mem[0] while word 0 is being written -> o_instruction shows the old value; the next read shows the new value.
- With INST_MEM_LOADER_CHECKSUM_EN, 1 word 01 02 03 04:
  - checksum 0x0A -> o_done=1, o_error=0, o_cpu_reset_n=1.
  - checksum 0x0B -> o_error=1, o_cpu_reset_n=0.
